conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/cnn_pkg.sv | 19 +
 rtl/line_buffer.sv | 25 ++
 rtl/conv_window_gen.sv | 164 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants: default image/kernel geometry and the
// derived number of output tiles per frame.
package cnn_pkg;

    localparam int CNN_IMAGE_WIDTH  = 28;
    localparam int CNN_IMAGE_HEIGHT = 28;
    localparam int CNN_KERNEL_SIZE  = 3;
    localparam int CNN_STRIDE       = 1;

    // Number of valid (unpadded) window positions along one axis.
    function automatic int tiles_per_axis(input int dim, input int k, input int s);
        return ((dim - k) / s) + 1;
    endfunction

    localparam int CNN_TILES_X         = tiles_per_axis(CNN_IMAGE_WIDTH, CNN_KERNEL_SIZE, CNN_STRIDE);
    localparam int CNN_TILES_Y         = tiles_per_axis(CNN_IMAGE_HEIGHT, CNN_KERNEL_SIZE, CNN_STRIDE);
    localparam int CNN_TILES_PER_FRAME = CNN_TILES_X * CNN_TILES_Y;

endpackage

// File: rtl/line_buffer.sv
// K-1 image lines stored side by side: one entry per column, bit j holds the
// pixel from j+1 rows above the row currently streaming in.
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Column storage; intentionally unreset, every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streams a binary raster image and emits every K x K convolution window
// (valid positions only, configurable stride) to a downstream PE array.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int IMAGE_WIDTH  = CNN_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = CNN_IMAGE_HEIGHT,
    parameter int KERNEL_SIZE  = CNN_KERNEL_SIZE,
    parameter int STRIDE       = CNN_STRIDE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pix_valid,
    input  logic                            pix_data,
    output logic                            pix_ready,
    output logic                            tile_valid,
    output logic                            tile_data [KERNEL_SIZE*KERNEL_SIZE],
    input  logic                            tile_ready,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] tile_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  tile_col,
    output logic                            frame_done
);

    localparam int K   = KERNEL_SIZE;
    localparam int N   = K * K;
    localparam int XW  = $clog2(IMAGE_WIDTH);
    localparam int YW  = $clog2(IMAGE_HEIGHT);
    localparam int LBW = K - 1;

    localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMAGE_HEIGHT - 1);
    localparam logic [XW-1:0] X_STEP  = XW'(STRIDE);
    localparam logic [YW-1:0] Y_STEP  = YW'(STRIDE);
    localparam logic [XW-1:0] X_ONE   = XW'(1'b1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1'b1);
    localparam logic [XW-1:0] X_TMAX  = XW'(tiles_per_axis(IMAGE_WIDTH, K, STRIDE) - 1);
    localparam logic [YW-1:0] Y_TMAX  = YW'(tiles_per_axis(IMAGE_HEIGHT, K, STRIDE) - 1);

    logic [XW-1:0]  x_r;
    logic [YW-1:0]  y_r;
    logic           win_r [N];
    logic           tile_valid_r;
    logic           tile_data_r [N];
    logic [YW-1:0]  tile_row_r;
    logic [XW-1:0]  tile_col_r;
    logic           tile_last_r;

    logic           accept_s;
    logic           emit_s;
    logic [XW-1:0]  dx_s;
    logic [YW-1:0]  dy_s;
    logic [XW-1:0]  col_next_s;
    logic [YW-1:0]  row_next_s;
    logic           last_next_s;
    logic           win_next_s [N];
    logic [LBW-1:0] lb_rd_s;
    logic [LBW-1:0] lb_wr_s;

    assign pix_ready  = !tile_valid_r || tile_ready;
    assign accept_s   = pix_valid && pix_ready;
    assign tile_valid = tile_valid_r;
    assign tile_data  = tile_data_r;
    assign tile_row   = tile_row_r;
    assign tile_col   = tile_col_r;
    assign frame_done = tile_valid_r && tile_ready && tile_last_r;

    line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH (LBW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (x_r),
        .wr_data (lb_wr_s),
        .rd_data (lb_rd_s)
    );

    // Line-buffer write word: new pixel enters bit 0, older lines age by one.
    always_comb begin
        lb_wr_s    = '0;
        lb_wr_s[0] = pix_data;
        for (int j = 1; j < LBW; j++) begin
            lb_wr_s[j] = lb_rd_s[j-1];
        end
    end

    // Next window: shift left one column, right column = this column top-to-bottom.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            win_next_s[i] = win_r[i];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_next_s[r*K+c] = win_r[r*K+c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_next_s[r*K+K-1] = lb_rd_s[K-2-r];
        end
        win_next_s[N-1] = pix_data;
    end

    // Window completion test and output-map coordinates for the accepted pixel.
    always_comb begin
        dx_s        = x_r - X_FIRST;
        dy_s        = y_r - Y_FIRST;
        col_next_s  = dx_s / X_STEP;
        row_next_s  = dy_s / Y_STEP;
        last_next_s = (row_next_s == Y_TMAX) && (col_next_s == X_TMAX);
        if (accept_s && (x_r >= X_FIRST) && (y_r >= Y_FIRST) &&
            ((dx_s % X_STEP) == '0) && ((dy_s % Y_STEP) == '0)) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
    end

    // Raster position counters and the shift window advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= '0;
            y_r <= '0;
            for (int i = 0; i < N; i++) begin
                win_r[i] <= 1'b0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < N; i++) begin
                win_r[i] <= win_next_s[i];
            end
            if (x_r == X_LAST) begin
                x_r <= '0;
                y_r <= (y_r == Y_LAST) ? '0 : (y_r + Y_ONE);
            end else begin
                x_r <= x_r + X_ONE;
            end
        end
    end

    // Output tile register: load on completion, drop after consumption, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_valid_r <= 1'b0;
            tile_row_r   <= '0;
            tile_col_r   <= '0;
            tile_last_r  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                tile_data_r[i] <= 1'b0;
            end
        end else if (emit_s) begin
            tile_valid_r <= 1'b1;
            tile_row_r   <= row_next_s;
            tile_col_r   <= col_next_s;
            tile_last_r  <= last_next_s;
            for (int i = 0; i < N; i++) begin
                tile_data_r[i] <= win_next_s[i];
            end
        end else if (tile_ready) begin
            tile_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen: a stride-1 and a stride-2 instance fed
// the same pixel stream, each checked cycle by cycle against an image-array model.
module tb_conv_window_gen;

    localparam int W = 28;
    localparam int H = 28;
    localparam int K = 3;
    localparam int N = K * K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pix_valid;
    logic       pix_data;
    logic       tile_ready;

    logic       pix_ready0, tile_valid0, fd0;
    logic       td0 [N];
    logic [4:0] trow0, tcol0;

    logic       pix_valid1, pix_ready1, tile_valid1, fd1;
    logic       td1 [N];
    logic [4:0] trow1, tcol1;

    assign pix_valid1 = pix_valid & pix_ready0;

    conv_window_gen #(
        .IMAGE_WIDTH (W), .IMAGE_HEIGHT (H), .KERNEL_SIZE (K), .STRIDE (1)
    ) u_dut_s1 (
        .clk (clk), .rst_n (rst_n), .pix_valid (pix_valid), .pix_data (pix_data),
        .pix_ready (pix_ready0), .tile_valid (tile_valid0), .tile_data (td0),
        .tile_ready (tile_ready), .tile_row (trow0), .tile_col (tcol0), .frame_done (fd0)
    );

    conv_window_gen #(
        .IMAGE_WIDTH (W), .IMAGE_HEIGHT (H), .KERNEL_SIZE (K), .STRIDE (2)
    ) u_dut_s2 (
        .clk (clk), .rst_n (rst_n), .pix_valid (pix_valid1), .pix_data (pix_data),
        .pix_ready (pix_ready1), .tile_valid (tile_valid1), .tile_data (td1),
        .tile_ready (1'b1), .tile_row (trow1), .tile_col (tcol1), .frame_done (fd1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic           src [H][W];
    int             mx, my, pix_acc;
    int             stride_of [2];
    logic           ev [2];
    int             erow [2];
    int             ecol [2];
    logic [N-1:0]   edata [2];
    logic           elast [2];
    int             tiles [2];
    int             fds [2];
    int             pv_pct, tr_pct, hold_cnt, nonzero;
    logic           hold_arm;
    logic [N-1:0]   got35, got57;

    function automatic logic [N-1:0] window_at(input int top, input int left);
        logic [N-1:0] v;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[r*K+c] = src[top+r][left+c];
        return v;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0;
        for (int m = 0; m < 2; m++) begin
            ev[m] = 1'b0; erow[m] = 0; ecol[m] = 0; edata[m] = '0; elast[m] = 1'b0;
            tiles[m] = 0; fds[m] = 0;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] obs [2];
        logic obs_v [2];
        int   obs_r [2];
        int   obs_c [2];
        logic tr_m [2];
        logic fd_obs [2];
        logic exp_ready, acc;
        int   s;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            obs[0][i] = td0[i];
            obs[1][i] = td1[i];
        end
        obs_v[0] = tile_valid0; obs_r[0] = int'(trow0); obs_c[0] = int'(tcol0);
        obs_v[1] = tile_valid1; obs_r[1] = int'(trow1); obs_c[1] = int'(tcol1);
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("s%0d_tile_valid", stride_of[m]), 64'(obs_v[m]), 64'(ev[m]));
            if (ev[m]) begin
                check_val($sformatf("s%0d_tile_row", stride_of[m]), 64'(obs_r[m]), 64'(erow[m]));
                check_val($sformatf("s%0d_tile_col", stride_of[m]), 64'(obs_c[m]), 64'(ecol[m]));
                check_val($sformatf("s%0d_tile_data", stride_of[m]), 64'(obs[m]), 64'(edata[m]));
            end
        end
        pix_valid = ($urandom_range(99) < pv_pct);
        if (hold_arm && ev[0] && erow[0] == 4 && ecol[0] == 4) begin
            hold_arm = 1'b0;
            hold_cnt = 10;
        end
        if (hold_cnt > 0) begin
            tile_ready = 1'b0;
            hold_cnt--;
        end else begin
            tile_ready = ($urandom_range(99) < tr_pct);
        end
        pix_data = src[my][mx];
        #1;
        exp_ready = !ev[0] || tile_ready;
        check_val("pix_ready", 64'(pix_ready0), 64'(exp_ready));
        tr_m[0] = tile_ready; tr_m[1] = 1'b1;
        fd_obs[0] = fd0; fd_obs[1] = fd1;
        acc = pix_valid && exp_ready;
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("s%0d_frame_done", stride_of[m]), 64'(fd_obs[m]),
                      64'(ev[m] && tr_m[m] && elast[m]));
            if (fd_obs[m]) fds[m]++;
            if (obs_v[m] && tr_m[m]) begin
                tiles[m]++;
                if (m == 0) begin
                    if (obs[0] != '0) nonzero++;
                    if (obs_r[0] == 3 && obs_c[0] == 5) got35 = obs[0];
                    if (obs_r[0] == 5 && obs_c[0] == 7) got57 = obs[0];
                end
            end
            s = stride_of[m];
            if (acc && mx >= K-1 && my >= K-1 && (mx-K+1) % s == 0 && (my-K+1) % s == 0) begin
                ev[m]    = 1'b1;
                erow[m]  = (my - K + 1) / s;
                ecol[m]  = (mx - K + 1) / s;
                edata[m] = window_at(my - K + 1, mx - K + 1);
                elast[m] = (erow[m] == (H - K) / s) && (ecol[m] == (W - K) / s);
            end else if (tr_m[m]) begin
                ev[m] = 1'b0;
            end
        end
        if (acc) begin
            pix_acc++;
            mx++;
            if (mx == W) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end
        end
    endtask

    task automatic fill_src(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = (mode == 0) ? 1'($urandom_range(1)) : 1'b0;
        if (mode == 1) src[5][7] = 1'b1;
    endtask

    task automatic send_frame(input int mode);
        int start;
        int cyc;
        fill_src(mode);
        start = pix_acc;
        cyc = 0;
        while ((pix_acc - start) < W * H && cyc < W * H * 20) begin
            cycle();
            cyc++;
        end
        check_val("frame_pixels", 64'(pix_acc - start), 64'(W * H));
    endtask

    task automatic drain();
        int cyc;
        int saved;
        saved = pv_pct;
        pv_pct = 0;
        cyc = 0;
        while ((ev[0] || ev[1]) && cyc < 200) begin
            cycle();
            cyc++;
        end
        check_val("drain", 64'(ev[0] || ev[1]), 64'(0));
        pv_pct = saved;
    endtask

    task automatic end_checks(input int nf);
        check_val("s1_tile_count", 64'(tiles[0]), 64'(676 * nf));
        check_val("s2_tile_count", 64'(tiles[1]), 64'(169 * nf));
        check_val("s1_frame_done_count", 64'(fds[0]), 64'(nf));
        check_val("s2_frame_done_count", 64'(fds[1]), 64'(nf));
        for (int m = 0; m < 2; m++) begin
            tiles[m] = 0;
            fds[m] = 0;
        end
    endtask

    initial begin
        logic [N-1:0] rst_td;
        stride_of[0] = 1; stride_of[1] = 2;
        rst_n = 1'b0; pix_valid = 1'b0; pix_data = 1'b0; tile_ready = 1'b0;
        pv_pct = 100; tr_pct = 100; hold_cnt = 0; hold_arm = 1'b0;
        pix_acc = 0; nonzero = 0; got35 = '0; got57 = '0;
        model_reset();
        fill_src(0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) rst_td[i] = td0[i];
        check_val("rst_tile_valid", 64'(tile_valid0), 64'(0));
        check_val("rst_tile_row", 64'(trow0), 64'(0));
        check_val("rst_tile_col", 64'(tcol0), 64'(0));
        check_val("rst_tile_data", 64'(rst_td), 64'(0));
        check_val("rst_frame_done", 64'(fd0), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Full-rate frame
        send_frame(0);
        drain();
        end_checks(1);

        // Single set pixel at row 5, column 7
        nonzero = 0;
        send_frame(1);
        drain();
        check_val("single_nonzero_tiles", 64'(nonzero), 64'(9));
        check_val("single_tile35_bit8", 64'(got35[8]), 64'(1));
        check_val("single_tile57_bit0", 64'(got57[0]), 64'(1));
        end_checks(1);

        // Backpressure for 10 cycles at tile (4,4)
        hold_arm = 1'b1;
        send_frame(0);
        drain();
        check_val("hold_triggered", 64'(hold_arm), 64'(0));
        end_checks(1);

        // Reset mid row 10, then a fresh frame
        fill_src(0);
        for (int c = 0; c < 2000 && !(my == 10 && mx == 13); c++) cycle();
        check_val("reset_point_reached", 64'(my * W + mx), 64'(10 * W + 13));
        @(negedge clk);
        #2;
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) rst_td[i] = td0[i];
        check_val("async_rst_tile_valid_s1", 64'(tile_valid0), 64'(0));
        check_val("async_rst_tile_valid_s2", 64'(tile_valid1), 64'(0));
        check_val("async_rst_tile_rowcol", 64'({trow0, tcol0}), 64'(0));
        check_val("async_rst_tile_data", 64'(rst_td), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(0);
        drain();
        end_checks(1);

        // Random throttling over two back-to-back frames
        pv_pct = 60;
        tr_pct = 55;
        send_frame(0);
        send_frame(0);
        drain();
        end_checks(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
